// File: rtl/mfp_als_light_filter.sv
// mfp_als_light_filter: ambient-light post-processing for the PMOD ALS receiver.
// Samples raw[12:5] every 2^PERIOD_LOG2 clocks, boxcar-averages 2^AVG_LOG2
// samples, and drives a hysteresis bright/dark flag with a sticky interrupt.
// Optional build macro MFP_ALS_FILTER_MINMAX_EN adds min/max tracking of avg.
module mfp_als_light_filter #(
    parameter int unsigned PERIOD_LOG2 = 22,
    parameter int unsigned AVG_LOG2    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] raw,
    input  logic [7:0]  thr_high,
    input  logic [7:0]  thr_low,
    input  logic        irq_ack,
`ifdef MFP_ALS_FILTER_MINMAX_EN
    input  logic        minmax_clear,
    output logic [7:0]  avg_min,
    output logic [7:0]  avg_max,
`endif
    output logic [7:0]  avg,
    output logic        avg_valid,
    output logic        bright,
    output logic        irq
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        DARK   = 1'b0,
        BRIGHT = 1'b1
    } light_state_t;

    logic [PERIOD_LOG2-1:0] timer;
    logic                   tick;
    logic                   tick_d1;
    logic                   tick_d2;
    logic [7:0]             sample;
    logic [7:0]             ring [DEPTH];
    logic [AVG_LOG2-1:0]    wr_ptr;
    logic [AVG_LOG2:0]      fill;
    logic [SUM_W-1:0]       sum;
    light_state_t           state;
    light_state_t           state_next;

    assign tick   = &timer;
    assign sample = raw[12:5];
    assign bright = (state == BRIGHT);

    // Free-running sample timer; tick fires when it is all ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Delay tick to sequence the average and hysteresis stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
        end else begin
            tick_d1 <= tick;
            tick_d2 <= tick_d1;
        end
    end

    // Stage T: replace the oldest ring entry and keep sum equal to the ring total.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            sum    <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (tick) begin
            ring[wr_ptr] <= sample;
            sum          <= sum + SUM_W'(sample) - SUM_W'(ring[wr_ptr]);
            wr_ptr       <= wr_ptr + 1'b1;
            if (fill != FILL_FULL) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Stage T+1: truncating divide of the window sum; valid once the window is full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avg       <= '0;
            avg_valid <= 1'b0;
        end else if (tick_d1) begin
            avg       <= sum[SUM_W-1:AVG_LOG2];
            avg_valid <= (fill == FILL_FULL);
        end
    end

    // Stage T+2: hysteresis, checking only the threshold for the current state.
    always_comb begin
        state_next = state;
        if (tick_d2 && avg_valid) begin
            case (state)
                DARK:    if (avg >= thr_high) state_next = BRIGHT;
                BRIGHT:  if (avg <= thr_low)  state_next = DARK;
                default: state_next = DARK;
            endcase
        end
    end

    // State register and sticky irq; a transition beats a coincident acknowledge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= DARK;
            irq   <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef MFP_ALS_FILTER_MINMAX_EN
    logic [7:0] avg_new;
    logic       valid_new;

    assign avg_new   = sum[SUM_W-1:AVG_LOG2];
    assign valid_new = (fill == FILL_FULL);

    // Track extremes of valid averages; a clear during an update seeds both with the new avg.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avg_min <= '1;
            avg_max <= '0;
        end else if (tick_d1 && valid_new) begin
            if (minmax_clear) begin
                avg_min <= avg_new;
                avg_max <= avg_new;
            end else begin
                if (avg_new < avg_min) avg_min <= avg_new;
                if (avg_new > avg_max) avg_max <= avg_new;
            end
        end else if (minmax_clear) begin
            avg_min <= '1;
            avg_max <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_mfp_als_light_filter.sv
// Scoreboard bench for mfp_als_light_filter (PERIOD_LOG2=4, AVG_LOG2=3).
// Driver issues samples and pushes cycle-stamped expectations from a
// window-average reference model; a monitor pops and compares them.
module tb_mfp_als_light_filter;

    localparam int unsigned PL    = 4;
    localparam int unsigned AL    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PER   = 16;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b1;
    logic [15:0] raw      = '0;
    logic [7:0]  thr_high = 8'h60;
    logic [7:0]  thr_low  = 8'h40;
    logic        irq_ack  = 1'b0;
    logic [7:0]  avg;
    logic        avg_valid;
    logic        bright;
    logic        irq;
`ifdef MFP_ALS_FILTER_MINMAX_EN
    logic        minmax_clear = 1'b0;
    logic [7:0]  avg_min;
    logic [7:0]  avg_max;
`endif

    mfp_als_light_filter #(
        .PERIOD_LOG2(PL),
        .AVG_LOG2   (AL)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .raw         (raw),
        .thr_high    (thr_high),
        .thr_low     (thr_low),
        .irq_ack     (irq_ack),
`ifdef MFP_ALS_FILTER_MINMAX_EN
        .minmax_clear(minmax_clear),
        .avg_min     (avg_min),
        .avg_max     (avg_max),
`endif
        .avg         (avg),
        .avg_valid   (avg_valid),
        .bright      (bright),
        .irq         (irq)
    );

    always #5 clock = ~clock;

    // Posedges since reset release.
    int unsigned cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt <= 0;
        else          cnt <= cnt + 1;
    end

    typedef struct {
        int unsigned cyc;
        logic [7:0]  avg;
        logic        valid;
        logic        bright;
        logic        irq;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [7:0] win[$];
    logic       m_valid;
    logic       m_bright;
    logic       m_irq;
    logic [7:0] m_avg;
    logic [7:0] m_min;
    logic [7:0] m_max;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        win.delete();
        m_valid  = 1'b0;
        m_bright = 1'b0;
        m_irq    = 1'b0;
        m_avg    = 8'h00;
        m_min    = 8'hFF;
        m_max    = 8'h00;
    endtask

    function automatic exp_t make_exp(input int unsigned cyc);
        exp_t e;
        e.cyc    = cyc;
        e.avg    = m_avg;
        e.valid  = m_valid;
        e.bright = m_bright;
        e.irq    = m_irq;
        e.mn     = m_min;
        e.mx     = m_max;
        return e;
    endfunction

    task automatic at_neg(input int unsigned target);
        int unsigned guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (cnt != target && guard < 64);
        if (cnt != target) begin
            n_checks++;
            $display("FAIL sync: cycle %0d expected %0d", cnt, target);
        end
    endtask

    // Monitor: compare each expectation at the negedge of its stamped cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && exp_q.size() > 0 && exp_q[0].cyc <= cnt) begin
                e = exp_q.pop_front();
                if (e.cyc != cnt) begin
                    check("missed_slot", 16'(cnt), 16'(e.cyc));
                end else begin
                    check("avg",       16'(avg),       16'(e.avg));
                    check("avg_valid", 16'(avg_valid), 16'(e.valid));
                    check("bright",    16'(bright),    16'(e.bright));
                    check("irq",       16'(irq),       16'(e.irq));
`ifdef MFP_ALS_FILTER_MINMAX_EN
                    check("avg_min",   16'(avg_min),   16'(e.mn));
                    check("avg_max",   16'(avg_max),   16'(e.mx));
`endif
                end
            end
        end
    end

    // One sample period. ack_mode: 0 none, 1 coincident with hysteresis, 2 mid-period.
    // clr_mode: 0 none, 1 coincident with avg update, 2 mid-period.
    task automatic do_sample(input logic [7:0] code, input int ack_mode, input int clr_mode);
        int unsigned base;
        int          total;
        logic        changed;
        logic [15:0] r;
        base = (cnt / PER + 1) * PER;
        r = 16'($urandom);
        r[12:5] = code;
        raw = r;

        win.push_back(code);
        if (win.size() > DEPTH) void'(win.pop_front());
        total = 0;
        foreach (win[i]) total += int'(win[i]);
        m_avg = 8'(total / DEPTH);
        if (win.size() == DEPTH) m_valid = 1'b1;
        changed = 1'b0;
        if (m_valid) begin
            if (!m_bright && m_avg >= thr_high) changed = 1'b1;
            else if (m_bright && m_avg <= thr_low) changed = 1'b1;
        end
        if (changed) begin
            m_bright = !m_bright;
            m_irq    = 1'b1;
        end else if (ack_mode == 1) begin
            m_irq = 1'b0;
        end
`ifdef MFP_ALS_FILTER_MINMAX_EN
        if (m_valid) begin
            if (clr_mode == 1) begin
                m_min = m_avg;
                m_max = m_avg;
            end else begin
                if (m_avg < m_min) m_min = m_avg;
                if (m_avg > m_max) m_max = m_avg;
            end
        end else if (clr_mode == 1) begin
            m_min = 8'hFF;
            m_max = 8'h00;
        end
`endif
        exp_q.push_back(make_exp(base + 2));

        at_neg(base);
`ifdef MFP_ALS_FILTER_MINMAX_EN
        if (clr_mode == 1) minmax_clear = 1'b1;
`endif
        at_neg(base + 1);
`ifdef MFP_ALS_FILTER_MINMAX_EN
        minmax_clear = 1'b0;
`endif
        if (ack_mode == 1) irq_ack = 1'b1;
        at_neg(base + 2);
        irq_ack = 1'b0;
        raw = 16'($urandom);   // off-tick changes must be ignored

        at_neg(base + 6);
`ifdef MFP_ALS_FILTER_MINMAX_EN
        if (clr_mode == 2) begin
            minmax_clear = 1'b1;
            m_min = 8'hFF;
            m_max = 8'h00;
            exp_q.push_back(make_exp(base + 7));
        end
`endif
        at_neg(base + 7);
`ifdef MFP_ALS_FILTER_MINMAX_EN
        minmax_clear = 1'b0;
`endif
        at_neg(base + 8);
        if (ack_mode == 2) begin
            irq_ack = 1'b1;
            m_irq = 1'b0;
            exp_q.push_back(make_exp(base + 9));
        end
        at_neg(base + 9);
        irq_ack = 1'b0;
        at_neg(base + 10);
    endtask

    // Assert reset between clock edges, check outputs immediately, release on a negedge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_avg",       16'(avg),       16'h0);
        check("rst_avg_valid", 16'(avg_valid), 16'h0);
        check("rst_bright",    16'(bright),    16'h0);
        check("rst_irq",       16'(irq),       16'h0);
`ifdef MFP_ALS_FILTER_MINMAX_EN
        check("rst_avg_min",   16'(avg_min),   16'hFF);
        check("rst_avg_max",   16'(avg_max),   16'h00);
`endif
        exp_q.delete();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Fill at 0x80: valid only after the eighth sample
        for (int i = 0; i < 8; i++) do_sample(8'h80, 0, 0);
        do_sample(8'h80, 2, 0);                       // ack with no transition
        for (int i = 0; i < 8; i++) do_sample(8'h20, 0, 0);
        // Step up to 0xA0: rises at k=4 with a coincident ack
        for (int i = 1; i <= 8; i++) do_sample(8'hA0, (i == 4) ? 1 : 0, 0);
        // Step down: clear irq first, bright falls at avg 0x40
        for (int i = 1; i <= 8; i++) do_sample(8'h20, (i == 1) ? 2 : 0, 0);
        for (int i = 1; i <= 8; i++) do_sample(8'hA0, 0, 0);

        // Reset while bright=1 and irq=1, then refill
        @(negedge clock);
        do_reset();
        for (int i = 0; i < 8; i++) do_sample(8'h80, 0, 0);
        do_sample(8'h30, 0, 0);
        do_sample(8'h90, 0, 2);
        do_sample(8'h50, 0, 1);
        do_sample(8'h50, 0, 0);

        // Randomized phase, including inverted thresholds
        for (int i = 0; i < 40; i++) begin
            thr_high = 8'($urandom_range(8'h50, 8'hB0));
            if ($urandom_range(0, 5) == 0) thr_low = thr_high + 8'($urandom_range(0, 16));
            else                           thr_low = thr_high - 8'($urandom_range(0, 48));
            do_sample(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)));
        end

        at_neg(cnt + 4);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
